// File: rtl/sdram_responder.sv
// sdram_responder: device-side SDRAM model for checking an SDRAM controller.
// Decodes the command pins and follows the init sequence. It tracks open
// banks and the tRCD/tRP/tRFC/tMRD windows, serves single-word reads and
// writes from an internal store, and latches the first protocol violation.
module sdram_responder #(
  parameter int ROW_WIDTH      = 13,
  parameter int COL_WIDTH      = 9,
  parameter int BANK_WIDTH     = 2,
  parameter int ROW_STORE_BITS = 4,
  parameter int COL_STORE_BITS = 4,
  parameter int TRCD           = 2,
  parameter int TRP            = 2,
  parameter int TRFC           = 7,
  parameter int TMRD           = 2,
  parameter int MAX_REF_GAP    = 1040,
  parameter int ADDR_WIDTH     = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BANK_WIDTH-1:0] bank_addr,
  input  logic                  clock_enable,
  input  logic                  cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic                  data_mask_low,
  input  logic                  data_mask_high,
  input  logic [15:0]           dq_in,
  output logic [15:0]           dq_out,
  output logic                  dq_oe,
  output logic                  init_done,
  output logic                  protocol_error,
  output logic [3:0]            error_code,
  output logic [15:0]           refresh_count
);

  localparam int NBANK = 1 << BANK_WIDTH;
  localparam int IDX_W = BANK_WIDTH + ROW_STORE_BITS + COL_STORE_BITS;
  localparam int DEPTH = 1 << IDX_W;
  localparam int BMAX  = (TRCD > TRP) ? TRCD : TRP;
  localparam int GMAX  = (TRFC > TMRD) ? TRFC : TMRD;
  localparam int CNT_W = $clog2(BMAX + 1);
  localparam int GT_W  = $clog2(GMAX + 1);
  localparam int GAP_W = $clog2(MAX_REF_GAP + 1);

  localparam logic [3:0] ERR_INIT   = 4'd1;
  localparam logic [3:0] ERR_TIMING = 4'd2;
  localparam logic [3:0] ERR_IDLE   = 4'd3;
  localparam logic [3:0] ERR_DBLACT = 4'd4;
  localparam logic [3:0] ERR_OPEN   = 4'd5;
  localparam logic [3:0] ERR_MODE   = 4'd6;
  localparam logic [3:0] ERR_LATE   = 4'd7;
  localparam logic [3:0] ERR_BUS    = 4'd8;

  typedef enum logic [2:0] {
    ST_WAIT_PALL = 3'd0,
    ST_WAIT_REF1 = 3'd1,
    ST_WAIT_REF2 = 3'd2,
    ST_WAIT_MRS  = 3'd3,
    ST_MRD_WAIT  = 3'd4,
    ST_READY     = 3'd5
  } init_state_e;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_ACT   = 3'd1,
    CMD_READ  = 3'd2,
    CMD_WRITE = 3'd3,
    CMD_PRE   = 3'd4,
    CMD_REF   = 3'd5,
    CMD_MRS   = 3'd6
  } cmd_e;

  // State registers and their next-state values
  init_state_e               state_q, state_d;
  logic [NBANK-1:0]          active_q, active_d;
  logic [ROW_STORE_BITS-1:0] row_q [NBANK];
  logic [ROW_STORE_BITS-1:0] row_d [NBANK];
  logic [CNT_W-1:0]          bcnt_q [NBANK];
  logic [CNT_W-1:0]          bcnt_d [NBANK];
  logic [GT_W-1:0]           gtimer_q, gtimer_d;
  logic                      cl3_q, cl3_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic                      late_q, late_d;
  logic [2:0]                rd_vld_q, rd_vld_d;
  logic [15:0]               rd_dat_q [3];
  logic [15:0]               rd_dat_d [3];
  logic [15:0]               dq_out_q, dq_out_d;
  logic                      dq_oe_q, dq_oe_d;
  logic                      init_done_q, init_done_d;
  logic                      perr_q, perr_d;
  logic [3:0]                ecode_q, ecode_d;
  logic [15:0]               refcnt_q, refcnt_d;

  // Storage is deliberately never reset so contents survive a controller reset
  logic [15:0]               mem_q [DEPTH];

  cmd_e                      cmd_s;
  logic                      ready_s;
  logic                      any_active_s;
  logic                      mode_ok_s;
  logic [IDX_W-1:0]          idx_s;
  logic [15:0]               mem_rdata_s;
  logic                      mem_we_s;
  logic                      rd_issue_s;
  logic                      ref_ok_s;
  logic                      cmd_err_s;
  logic [3:0]                cmd_code_s;
  logic                      late_err_s;
  logic                      unused_addr_s;

  // Only a few address bits carry meaning here; fold the rest away.
  assign unused_addr_s = ^addr;

  assign idx_s       = {bank_addr, row_q[bank_addr], addr[COL_STORE_BITS-1:0]};
  assign mem_rdata_s = mem_q[idx_s];

  // Decode the command pins into a single command value
  always_comb begin
    cmd_s = CMD_NOP;
    if (clock_enable && !cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  cmd_s = CMD_ACT;
        3'b101:  cmd_s = CMD_READ;
        3'b100:  cmd_s = CMD_WRITE;
        3'b010:  cmd_s = CMD_PRE;
        3'b001:  cmd_s = CMD_REF;
        3'b000:  cmd_s = CMD_MRS;
        default: cmd_s = CMD_NOP;
      endcase
    end else begin
      cmd_s = CMD_NOP;
    end
  end

  // Command legality, init FSM, bank tracking and read pipeline next-state
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    row_d      = row_q;
    cl3_d      = cl3_q;
    mem_we_s   = 1'b0;
    rd_issue_s = 1'b0;
    ref_ok_s   = 1'b0;
    cmd_err_s  = 1'b0;
    cmd_code_s = 4'd0;
    for (int b = 0; b < NBANK; b++) begin
      bcnt_d[b] = (bcnt_q[b] != CNT_W'(0)) ? bcnt_q[b] - CNT_W'(1) : bcnt_q[b];
    end
    gtimer_d = (gtimer_q != GT_W'(0)) ? gtimer_q - GT_W'(1) : gtimer_q;

    any_active_s = |active_q;
    mode_ok_s    = ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && (addr[2:0] == 3'b000);
    // The cycle where tMRD expires already accepts commands.
    ready_s      = (state_q == ST_READY) ||
                   ((state_q == ST_MRD_WAIT) && (gtimer_q == GT_W'(0)));

    if ((state_q == ST_MRD_WAIT) && (gtimer_q == GT_W'(0))) begin
      state_d = ST_READY;
    end else begin
      state_d = state_q;
    end

    if (cmd_s == CMD_NOP) begin
      cmd_err_s = 1'b0;
    end else if (gtimer_q != GT_W'(0)) begin
      cmd_err_s  = 1'b1;
      cmd_code_s = ERR_TIMING;
    end else if (!ready_s) begin
      case (state_q)
        ST_WAIT_PALL: begin
          if ((cmd_s == CMD_PRE) && addr[10]) begin
            state_d  = ST_WAIT_REF1;
            active_d = '0;
            for (int b = 0; b < NBANK; b++) bcnt_d[b] = CNT_W'(TRP - 1);
          end else begin
            cmd_err_s  = 1'b1;
            cmd_code_s = ERR_INIT;
          end
        end
        ST_WAIT_REF1, ST_WAIT_REF2: begin
          if (cmd_s == CMD_REF) begin
            state_d  = (state_q == ST_WAIT_REF1) ? ST_WAIT_REF2 : ST_WAIT_MRS;
            ref_ok_s = 1'b1;
            gtimer_d = GT_W'(TRFC - 1);
          end else begin
            cmd_err_s  = 1'b1;
            cmd_code_s = ERR_INIT;
          end
        end
        ST_WAIT_MRS: begin
          if (cmd_s == CMD_REF) begin
            ref_ok_s = 1'b1;
            gtimer_d = GT_W'(TRFC - 1);
          end else if ((cmd_s == CMD_MRS) && mode_ok_s) begin
            state_d  = ST_MRD_WAIT;
            cl3_d    = (addr[6:4] == 3'd3);
            gtimer_d = GT_W'(TMRD - 1);
          end else if (cmd_s == CMD_MRS) begin
            cmd_err_s  = 1'b1;
            cmd_code_s = ERR_MODE;
          end else begin
            cmd_err_s  = 1'b1;
            cmd_code_s = ERR_INIT;
          end
        end
        default: begin
          cmd_err_s  = 1'b1;
          cmd_code_s = ERR_INIT;
        end
      endcase
    end else begin
      case (cmd_s)
        CMD_ACT: begin
          if (active_q[bank_addr]) begin
            cmd_err_s  = 1'b1;
            cmd_code_s = ERR_DBLACT;
          end else if (bcnt_q[bank_addr] != CNT_W'(0)) begin
            cmd_err_s  = 1'b1;
            cmd_code_s = ERR_TIMING;
          end else begin
            active_d[bank_addr] = 1'b1;
            row_d[bank_addr]    = addr[ROW_STORE_BITS-1:0];
            bcnt_d[bank_addr]   = CNT_W'(TRCD - 1);
          end
        end
        CMD_READ, CMD_WRITE: begin
          if (!active_q[bank_addr]) begin
            cmd_err_s  = 1'b1;
            cmd_code_s = ERR_IDLE;
          end else if (bcnt_q[bank_addr] != CNT_W'(0)) begin
            cmd_err_s  = 1'b1;
            cmd_code_s = ERR_TIMING;
          end else if ((cmd_s == CMD_WRITE) && rd_vld_q[0]) begin
            // Controller would drive DQ while we return read data.
            cmd_err_s  = 1'b1;
            cmd_code_s = ERR_BUS;
          end else begin
            rd_issue_s = (cmd_s == CMD_READ);
            mem_we_s   = (cmd_s == CMD_WRITE);
            if (addr[10]) begin
              active_d[bank_addr] = 1'b0;
              bcnt_d[bank_addr]   = CNT_W'(TRP - 1);
            end else begin
              active_d[bank_addr] = active_q[bank_addr];
            end
          end
        end
        CMD_PRE: begin
          for (int b = 0; b < NBANK; b++) begin
            if (addr[10] || (bank_addr == BANK_WIDTH'(b))) begin
              active_d[b] = 1'b0;
              bcnt_d[b]   = CNT_W'(TRP - 1);
            end else begin
              active_d[b] = active_q[b];
            end
          end
        end
        CMD_REF: begin
          if (any_active_s) begin
            cmd_err_s  = 1'b1;
            cmd_code_s = ERR_OPEN;
          end else begin
            ref_ok_s = 1'b1;
            gtimer_d = GT_W'(TRFC - 1);
          end
        end
        CMD_MRS: begin
          if (any_active_s) begin
            cmd_err_s  = 1'b1;
            cmd_code_s = ERR_OPEN;
          end else if (!mode_ok_s) begin
            cmd_err_s  = 1'b1;
            cmd_code_s = ERR_MODE;
          end else begin
            cl3_d    = (addr[6:4] == 3'd3);
            gtimer_d = GT_W'(TMRD - 1);
          end
        end
        default: begin
          cmd_err_s = 1'b0;
        end
      endcase
    end

    // Refresh gap watchdog, active only once init is complete.
    gap_d      = gap_q;
    late_d     = late_q;
    late_err_s = 1'b0;
    if (init_done_q) begin
      if (ref_ok_s) begin
        gap_d = GAP_W'(0);
      end else if (gap_q >= GAP_W'(MAX_REF_GAP)) begin
        gap_d = gap_q;
        if (!late_q) begin
          late_err_s = 1'b1;
          late_d     = 1'b1;
        end else begin
          late_err_s = 1'b0;
        end
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end else begin
      gap_d = GAP_W'(0);
    end

    refcnt_d = refcnt_q;
    if (ref_ok_s && ready_s && (refcnt_q != 16'hFFFF)) begin
      refcnt_d = refcnt_q + 16'd1;
    end else begin
      refcnt_d = refcnt_q;
    end

    // Sticky error flag; code keeps the first event only.
    perr_d  = perr_q | cmd_err_s | late_err_s;
    ecode_d = ecode_q;
    if (ecode_q == 4'd0) begin
      if (cmd_err_s) begin
        ecode_d = cmd_code_s;
      end else if (late_err_s) begin
        ecode_d = ERR_LATE;
      end else begin
        ecode_d = ecode_q;
      end
    end else begin
      ecode_d = ecode_q;
    end

    init_done_d = (state_d == ST_READY);

    // Read return pipeline: slot 0 drives DQ on the next edge.
    rd_vld_d    = {1'b0, rd_vld_q[2:1]};
    rd_dat_d[0] = rd_dat_q[1];
    rd_dat_d[1] = rd_dat_q[2];
    rd_dat_d[2] = 16'h0000;
    if (rd_issue_s) begin
      if (cl3_q) begin
        rd_vld_d[2] = 1'b1;
        rd_dat_d[2] = mem_rdata_s;
      end else begin
        rd_vld_d[1] = 1'b1;
        rd_dat_d[1] = mem_rdata_s;
      end
    end else begin
      rd_vld_d[2] = 1'b0;
    end
    dq_oe_d  = rd_vld_q[0];
    dq_out_d = rd_vld_q[0] ? rd_dat_q[0] : 16'h0000;
  end

  // Register all control state; synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT_PALL;
      active_q    <= '0;
      for (int b = 0; b < NBANK; b++) begin
        row_q[b]  <= '0;
        bcnt_q[b] <= '0;
      end
      gtimer_q    <= '0;
      cl3_q       <= 1'b0;
      gap_q       <= '0;
      late_q      <= 1'b0;
      rd_vld_q    <= 3'b000;
      for (int s = 0; s < 3; s++) rd_dat_q[s] <= 16'h0000;
      dq_out_q    <= 16'h0000;
      dq_oe_q     <= 1'b0;
      init_done_q <= 1'b0;
      perr_q      <= 1'b0;
      ecode_q     <= 4'd0;
      refcnt_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      row_q       <= row_d;
      bcnt_q      <= bcnt_d;
      gtimer_q    <= gtimer_d;
      cl3_q       <= cl3_d;
      gap_q       <= gap_d;
      late_q      <= late_d;
      rd_vld_q    <= rd_vld_d;
      rd_dat_q    <= rd_dat_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      init_done_q <= init_done_d;
      perr_q      <= perr_d;
      ecode_q     <= ecode_d;
      refcnt_q    <= refcnt_d;
    end
  end

  // Byte-masked write into the data store
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      if (!data_mask_low)  mem_q[idx_s][7:0]  <= dq_in[7:0];
      if (!data_mask_high) mem_q[idx_s][15:8] <= dq_in[15:8];
    end
  end

  assign dq_out         = dq_out_q;
  assign dq_oe          = dq_oe_q;
  assign init_done      = init_done_q;
  assign protocol_error = perr_q;
  assign error_code     = ecode_q;
  assign refresh_count  = refcnt_q;

endmodule
